// File: rtl/uart_cmd_regfile_if.sv
// Byte-stream link between the UART receiver/transmitter and the command
// decoder: a strobe-only receive channel and a valid/ready transmit channel.
interface uart_cmd_regfile_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // UART side: delivers received bytes, consumes response bytes.
    modport master (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    // Decoder side: consumes received bytes, produces response bytes.
    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/uart_cmd_regfile.sv
// UART command decoder and register file for the TTM control path.
// Parses AA BB CC CMD ADDR DATA.. CHK frames, executes write / read / restore
// against a register file and answers with an ACK/NAK response stream.
module uart_cmd_regfile #(
    parameter int                                NUM_REGS    = 16,
    parameter int                                DATA_BYTES  = 4,
    parameter int                                TIMEOUT_CYC = 50000,
    parameter logic [NUM_REGS*DATA_BYTES*8-1:0]  DEFAULTS    = '0
) (
    input  logic                               clk_50,
    input  logic                               reset_n,
    uart_cmd_regfile_if.slave                  bus,
    output logic [NUM_REGS*DATA_BYTES*8-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]                wr_strobe,
    output logic                               cmd_pulse,
    output logic [7:0]                         err_count
);

    localparam int W   = 8 * DATA_BYTES;
    localparam int AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int GW  = $clog2(TIMEOUT_CYC + 1);
    localparam int BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int RW  = (DATA_BYTES + 1) * 8;         // bytes after the ACK/NAK
    localparam int RCW = $clog2(DATA_BYTES + 2);

    localparam logic [7:0] HDR0        = 8'hAA;
    localparam logic [7:0] HDR1        = 8'hBB;
    localparam logic [7:0] HDR2        = 8'hCC;
    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;
    localparam logic [7:0] CMD_RESTORE = 8'h03;
    localparam logic [7:0] ACK         = 8'h06;
    localparam logic [7:0] NAK         = 8'h15;

    typedef enum logic [3:0] {
        S_H0, S_H1, S_H2, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [7:0]       r_cmd;
    logic [7:0]       r_addr;
    logic [7:0]       r_chk;
    logic [7:0]       r_xor;
    logic [W-1:0]     r_data;
    logic [BCW-1:0]   r_byte_cnt;
    logic [GW-1:0]    r_gap_cnt;

    logic [W-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_strobe;
    logic             r_cmd_pulse;
    logic [7:0]       r_err_count;

    logic [7:0]       r_tx_data;
    logic             r_tx_valid;
    logic [RW-1:0]    r_resp;
    logic [RCW-1:0]   r_resp_left;

    logic             w_in_frame;
    logic             w_timeout;
    logic             w_tx_fire;
    logic             w_data_last;
    logic             w_chk_ok;
    logic             w_cmd_ok;
    logic             w_addr_ok;
    logic             w_accept;
    logic [7:0]       w_status;
    logic             w_err_inc;
    logic [AW-1:0]    w_addr_idx;
    logic [W-1:0]     w_rd_val;

    assign w_in_frame  = (r_state inside {S_H1, S_H2, S_CMD, S_ADDR, S_DATA, S_CHK});
    // The gap counter holds TIMEOUT_CYC-1 after that many idle cycles; the
    // next idle edge is the TIMEOUT_CYC-th and abandons the frame.
    assign w_timeout   = w_in_frame && !bus.rx_valid && (r_gap_cnt == GW'(TIMEOUT_CYC - 1));
    assign w_tx_fire   = r_tx_valid && bus.tx_ready;
    assign w_data_last = (r_byte_cnt == BCW'(DATA_BYTES - 1));

    assign w_addr_idx  = r_addr[AW-1:0];
    assign w_rd_val    = r_regs[w_addr_idx];

    assign w_chk_ok    = (r_xor == r_chk);
    assign w_cmd_ok    = (r_cmd == CMD_WRITE) || (r_cmd == CMD_READ) || (r_cmd == CMD_RESTORE);
    assign w_addr_ok   = (r_cmd == CMD_RESTORE) || ({1'b0, r_addr} < 9'(NUM_REGS));
    assign w_err_inc   = ((r_state == S_EXEC) && !w_accept) || w_timeout;

    // Validation verdict for the frame sitting in EXEC; earlier checks win.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_accept = 1'b0;
        w_status = 8'h00;
        if (!w_chk_ok)       w_status = 8'hE1;
        else if (!w_cmd_ok)  w_status = 8'hE2;
        else if (!w_addr_ok) w_status = 8'hE3;
        else                 w_accept = 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk_50) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset_n) r_state <= S_H0;
        else          r_state <= w_next_state;
    end

    // Frame parser next-state: header resync, field sequencing, timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_H0:   if (bus.rx_valid && bus.rx_data == HDR0) w_next_state = S_H1;
            S_H1:   if (bus.rx_valid) begin
                        if (bus.rx_data == HDR1)      w_next_state = S_H2;
                        else if (bus.rx_data == HDR0) w_next_state = S_H1;
                        else                          w_next_state = S_H0;
                    end
            S_H2:   if (bus.rx_valid) begin
                        if (bus.rx_data == HDR2)      w_next_state = S_CMD;
                        else if (bus.rx_data == HDR0) w_next_state = S_H1;
                        else                          w_next_state = S_H0;
                    end
            S_CMD:  if (bus.rx_valid) w_next_state = S_ADDR;
            S_ADDR: if (bus.rx_valid) w_next_state = S_DATA;
            S_DATA: if (bus.rx_valid && w_data_last) w_next_state = S_CHK;
            S_CHK:  if (bus.rx_valid) w_next_state = S_EXEC;
            S_EXEC: w_next_state = S_RESP;
            S_RESP: if (w_tx_fire && r_resp_left == '0) w_next_state = S_H0;
            default: w_next_state = S_H0;
        endcase
        if (w_timeout) w_next_state = S_H0;
    end

    // Field capture, running checksum, data byte counter and inter-byte gap timer.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            r_cmd      <= '0;
            r_addr     <= '0;
            r_chk      <= '0;
            r_xor      <= '0;
            r_data     <= '0;
            r_byte_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            if (w_in_frame && !bus.rx_valid && !w_timeout) r_gap_cnt <= r_gap_cnt + 1'b1;
            else                                           r_gap_cnt <= '0;

            if (bus.rx_valid) begin
                case (r_state)
                    S_H2: r_xor <= '0;
                    S_CMD: begin
                        r_cmd <= bus.rx_data;
                        r_xor <= r_xor ^ bus.rx_data;
                    end
                    S_ADDR: begin
                        r_addr     <= bus.rx_data;
                        r_xor      <= r_xor ^ bus.rx_data;
                        r_byte_cnt <= '0;
                    end
                    S_DATA: begin
                        r_data     <= (r_data << 8) | W'(bus.rx_data);
                        r_xor      <= r_xor ^ bus.rx_data;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                    end
                    S_CHK: r_chk <= bus.rx_data;
                    default: ;
                endcase
            end
        end
    end

    // Command execution, register file, error counter and response shifter.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            // NOTE: the register file is configuration state with defined
            // power-up values, so it is reset like any flop rather than
            // treated as an uninitialised RAM.
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= DEFAULTS[i*W +: W];
            r_wr_strobe <= '0;
            r_cmd_pulse <= 1'b0;
            r_err_count <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_resp      <= '0;
            r_resp_left <= '0;
        end else begin
            r_wr_strobe <= '0;
            r_cmd_pulse <= 1'b0;

            if (w_err_inc && r_err_count != 8'hFF) r_err_count <= r_err_count + 1'b1;

            if (r_state == S_EXEC) begin
                r_tx_valid  <= 1'b1;
                r_resp_left <= RCW'(1);
                if (w_accept) begin
                    r_cmd_pulse <= 1'b1;
                    r_tx_data   <= ACK;
                    case (r_cmd)
                        CMD_WRITE: begin
                            r_regs[w_addr_idx]      <= r_data;
                            r_wr_strobe[w_addr_idx] <= 1'b1;
                            r_resp                  <= {r_addr, W'(0)};
                        end
                        CMD_READ: begin
                            r_resp      <= {r_addr, w_rd_val};
                            r_resp_left <= RCW'(DATA_BYTES + 1);
                        end
                        default: begin
                            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= DEFAULTS[i*W +: W];
                            r_wr_strobe <= '1;
                            r_resp      <= {8'hFF, W'(0)};
                        end
                    endcase
                end else begin
                    r_tx_data <= NAK;
                    r_resp    <= {w_status, W'(0)};
                end
            end else if (w_tx_fire) begin
                if (r_resp_left == '0) begin
                    r_tx_valid <= 1'b0;
                end else begin
                    r_tx_data   <= r_resp[RW-1 -: 8];
                    r_resp      <= r_resp << 8;
                    r_resp_left <= r_resp_left - 1'b1;
                end
            end
        end
    end

    // Flatten the register file onto the output bus.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_flat[i*W +: W] = r_regs[i];
    end

    assign wr_strobe    = r_wr_strobe;
    assign cmd_pulse    = r_cmd_pulse;
    assign err_count    = r_err_count;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;

endmodule

// File: tb/tb_uart_cmd_regfile.sv
// Directed bench for uart_cmd_regfile: a table of complete frames with
// hand-computed responses, plus sequences for resync, timeout, error
// counter saturation and reset during a response.
module tb_uart_cmd_regfile;

    localparam int NR = 16;
    localparam int DB = 4;
    localparam int W  = 32;
    localparam int T  = 40;
    localparam logic [511:0] DEF = (512'h0000_0FA0 << 32) | (512'hDEAD_BEEF << 160);

    logic         clk_50;
    logic         reset_n;
    logic [511:0] regs_flat;
    logic [15:0]  wr_strobe;
    logic         cmd_pulse;
    logic [7:0]   err_count;

    uart_cmd_regfile_if bus_if ();

    uart_cmd_regfile #(
        .NUM_REGS    (NR),
        .DATA_BYTES  (DB),
        .TIMEOUT_CYC (T),
        .DEFAULTS    (DEF)
    ) dut (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .bus       (bus_if),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .cmd_pulse (cmd_pulse),
        .err_count (err_count)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  chk;
        logic        slow;
        logic [3:0]  exp_len;
        logic [47:0] exp_bytes;
        logic [15:0] exp_wr;
        logic        exp_pulse;
        logic [7:0]  exp_err;
    } vec_t;

    int           checks   = 0;
    int           failures = 0;
    logic [511:0] model;
    vec_t         vecs [12];

    function automatic vec_t mk(input logic [7:0] cmd, input logic [7:0] addr,
                                input logic [31:0] data, input logic [7:0] chk,
                                input logic slow, input logic [3:0] len,
                                input logic [47:0] bytes, input logic [15:0] wr,
                                input logic pulse, input logic [7:0] err);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.data = data; v.chk = chk; v.slow = slow;
        v.exp_len = len; v.exp_bytes = bytes; v.exp_wr = wr;
        v.exp_pulse = pulse; v.exp_err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic send_raw(input logic [7:0] b);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        tick();
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [31:0] data, input logic [7:0] chk);
        send_raw(8'hAA); send_raw(8'hBB); send_raw(8'hCC);
        send_raw(cmd);   send_raw(addr);
        send_raw(data[31:24]); send_raw(data[23:16]);
        send_raw(data[15:8]);  send_raw(data[7:0]);
        send_raw(chk);
    endtask

    // Called right after the CHK byte edge: checks EXEC, the N+2 outputs and
    // the full response stream, honouring tx_ready stalls.
    task automatic expect_resp(input string name, input logic [15:0] exp_wr,
                               input logic exp_pulse, input int exp_len,
                               input logic [47:0] exp_bytes, input logic slow,
                               input logic [7:0] exp_err);
        logic [47:0] got;
        logic [7:0]  prev;
        logic        stall;
        int          n, k, cyc;
        check({name, " exec_tx_valid"}, bus_if.tx_valid, 1'b0);
        tick();
        check({name, " wr_strobe"}, wr_strobe, exp_wr);
        check({name, " cmd_pulse"}, cmd_pulse, exp_pulse);
        check({name, " tx_valid_rise"}, bus_if.tx_valid, 1'b1);
        check({name, " regs"}, regs_flat, model);
        check({name, " err_count"}, err_count, exp_err);
        got = '0; prev = '0; stall = 1'b0; n = 0; k = 0; cyc = 0;
        while (n < exp_len && cyc < 100) begin
            bus_if.tx_ready = slow ? (k % 3 == 0) : 1'b1;
            if (stall) begin
                check({name, " hold_valid"}, bus_if.tx_valid, 1'b1);
                check({name, " hold_data"}, bus_if.tx_data, prev);
            end
            if (bus_if.tx_valid && bus_if.tx_ready) begin
                got[47-8*n -: 8] = bus_if.tx_data;
                n++;
            end
            stall = bus_if.tx_valid && !bus_if.tx_ready;
            prev  = bus_if.tx_data;
            k++;
            tick();
            cyc++;
        end
        bus_if.tx_ready = 1'b1;
        check({name, " resp_count"}, n, exp_len);
        check({name, " resp_bytes"}, got, exp_bytes);
        check({name, " tx_valid_drop"}, bus_if.tx_valid, 1'b0);
        check({name, " strobe_one_cycle"}, wr_strobe, 16'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] err_before;
        logic       saw_valid;
        int         idx;

        vecs[0]  = mk(8'h01, 8'h03, 32'h1234_5678, 8'h0A, 1'b0, 4'd2, 48'h0603_0000_0000, 16'h0008, 1'b1, 8'd0);
        vecs[1]  = mk(8'h02, 8'h03, 32'h0000_0000, 8'h01, 1'b1, 4'd6, 48'h0603_1234_5678, 16'h0000, 1'b1, 8'd0);
        vecs[2]  = mk(8'h01, 8'h05, 32'hAABB_CCDD, 8'h00, 1'b0, 4'd2, 48'h15E1_0000_0000, 16'h0000, 1'b0, 8'd1);
        vecs[3]  = mk(8'h01, 8'h20, 32'h1122_3344, 8'h65, 1'b0, 4'd2, 48'h15E3_0000_0000, 16'h0000, 1'b0, 8'd2);
        vecs[4]  = mk(8'h02, 8'h01, 32'h0000_0000, 8'h03, 1'b1, 4'd6, 48'h0601_0000_0FA0, 16'h0000, 1'b1, 8'd2);
        vecs[5]  = mk(8'h07, 8'h02, 32'h0000_0000, 8'h05, 1'b0, 4'd2, 48'h15E2_0000_0000, 16'h0000, 1'b0, 8'd3);
        vecs[6]  = mk(8'h02, 8'h10, 32'h0000_0000, 8'h12, 1'b0, 4'd2, 48'h15E3_0000_0000, 16'h0000, 1'b0, 8'd4);
        vecs[7]  = mk(8'h01, 8'h0F, 32'hCAFE_F00D, 8'hC7, 1'b0, 4'd2, 48'h060F_0000_0000, 16'h8000, 1'b1, 8'd4);
        vecs[8]  = mk(8'h09, 8'h40, 32'h0000_0000, 8'h00, 1'b0, 4'd2, 48'h15E1_0000_0000, 16'h0000, 1'b0, 8'd5);
        vecs[9]  = mk(8'h03, 8'h55, 32'h0000_0000, 8'h56, 1'b0, 4'd2, 48'h06FF_0000_0000, 16'hFFFF, 1'b1, 8'd5);
        vecs[10] = mk(8'h02, 8'h0F, 32'h0000_0000, 8'h0D, 1'b0, 4'd6, 48'h060F_0000_0000, 16'h0000, 1'b1, 8'd5);
        vecs[11] = mk(8'h02, 8'h05, 32'h0000_0000, 8'h07, 1'b1, 4'd6, 48'h0605_DEAD_BEEF, 16'h0000, 1'b1, 8'd5);

        reset_n         = 1'b0;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.tx_ready = 1'b1;
        model           = DEF;
        repeat (3) tick();

        check("reset regs", regs_flat, DEF);
        check("reset reg1", regs_flat[63:32], 32'h0000_0FA0);
        check("reset tx_valid", bus_if.tx_valid, 1'b0);
        check("reset tx_data", bus_if.tx_data, 8'h00);
        check("reset err_count", err_count, 8'h00);
        check("reset wr_strobe", wr_strobe, 16'h0);
        check("reset cmd_pulse", cmd_pulse, 1'b0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].exp_pulse && vecs[i].cmd == 8'h01) begin
                idx = int'(vecs[i].addr);
                model[idx*W +: W] = vecs[i].data;
            end
            if (vecs[i].exp_pulse && vecs[i].cmd == 8'h03) model = DEF;
            send_frame(vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].chk);
            expect_resp($sformatf("vec%0d", i), vecs[i].exp_wr, vecs[i].exp_pulse,
                        int'(vecs[i].exp_len), vecs[i].exp_bytes, vecs[i].slow,
                        vecs[i].exp_err);
        end

        // Header resynchronisation: junk byte and a doubled AA before BB CC.
        send_raw(8'h55); send_raw(8'hAA); send_raw(8'hAA); send_raw(8'hBB); send_raw(8'hCC);
        send_raw(8'h01); send_raw(8'h00);
        send_raw(8'h01); send_raw(8'h02); send_raw(8'h03); send_raw(8'h04);
        send_raw(8'h05);
        model[31:0] = 32'h0102_0304;
        expect_resp("resync", 16'h0001, 1'b1, 2, 48'h0600_0000_0000, 1'b0, 8'd5);

        // Partial frame abandoned after an idle gap: no response, one error.
        send_raw(8'hAA); send_raw(8'hBB); send_raw(8'hCC); send_raw(8'h01);
        saw_valid = 1'b0;
        repeat (T - 3) begin
            tick();
            if (bus_if.tx_valid) saw_valid = 1'b1;
        end
        check("timeout not_early", err_count, 8'd5);
        repeat (13) begin
            tick();
            if (bus_if.tx_valid) saw_valid = 1'b1;
        end
        check("timeout err_count", err_count, 8'd6);
        check("timeout no_resp", saw_valid, 1'b0);

        // Gap just under the limit inside a frame still completes it.
        send_raw(8'hAA); send_raw(8'hBB); send_raw(8'hCC); send_raw(8'h01); send_raw(8'h00);
        repeat (T - 2) tick();
        send_raw(8'h11); send_raw(8'h22); send_raw(8'h33); send_raw(8'h44);
        send_raw(8'h45);
        model[31:0] = 32'h1122_3344;
        expect_resp("near_timeout", 16'h0001, 1'b1, 2, 48'h0600_0000_0000, 1'b0, 8'd6);

        // Error counter saturates at 255.
        for (int i = 0; i < 255; i++) begin
            send_frame(8'h07, 8'h00, 32'h0, 8'h00);
            repeat (5) tick();
        end
        check("err_count saturate", err_count, 8'hFF);
        check("reject keeps regs", regs_flat, model);

        // Reset asserted while a response is stalled on tx_ready.
        bus_if.tx_ready = 1'b0;
        send_frame(8'h02, 8'h01, 32'h0, 8'h03);
        tick();
        tick();
        check("midresp tx_valid", bus_if.tx_valid, 1'b1);
        check("midresp tx_data", bus_if.tx_data, 8'h06);
        reset_n = 1'b0;
        tick();
        check("midresp reset tx_valid", bus_if.tx_valid, 1'b0);
        check("midresp reset tx_data", bus_if.tx_data, 8'h00);
        check("midresp reset err", err_count, 8'h00);
        check("midresp reset regs", regs_flat, DEF);
        reset_n         = 1'b1;
        bus_if.tx_ready = 1'b1;
        saw_valid       = 1'b0;
        repeat (6) begin
            tick();
            if (bus_if.tx_valid) saw_valid = 1'b1;
        end
        check("midresp no_resume", saw_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_regfile.md
# uart_cmd_regfile

Parametrised UART command decoder and register file for the TTM control path, between the UART receiver/transmitter and the generator and delay configuration logic. It parses checksummed byte frames into a register file of configurable depth and width, and writes, reads back or restores registers. Each command returns a status/readback response over a valid/ready transmit handshake. Inter-byte timeouts, header resynchronisation and an error counter make the control link robust.

## Interface
- NUM_REGS, 16: number of registers, 2..256.
- DATA_BYTES, 4: bytes per register (register width = 8*DATA_BYTES).
- TIMEOUT_CYC, 50000: maximum clk_50 cycles between consecutive bytes inside a frame.
- DEFAULTS, all zero: flat NUM_REGS*DATA_BYTES*8 vector of reset values; register i is the slice [i*W +: W].
- clk_50  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe per received byte.
- rx_data  in  8  received byte, valid while rx_valid=1.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid; held until it is accepted.
- tx_ready  in  1  transmitter accepts the byte when tx_valid=1 and tx_ready=1.
- regs_flat  out  NUM_REGS*DATA_BYTES*8  register contents, register i at [i*W +: W].
- wr_strobe  out  NUM_REGS  one-cycle pulse per register, coincident with its new value.
- cmd_pulse  out  1  one-cycle pulse on every successfully executed command.
- err_count  out  8  saturating count of rejected frames.

## Operation
- Frame, in byte order: AA BB CC CMD ADDR D[DATA_BYTES-1]..D[0] CHK. Data is sent MSB first. CHK is the XOR of CMD, ADDR and all data bytes.
- Commands:
  - 0x01 write: reg[ADDR] <= data.
  - 0x02 read: data bytes are ignored but must be present.
  - 0x03 restore: all registers <= DEFAULTS; ADDR is ignored.
- FSM states: H0, H1, H2, CMD, ADDR, DATA, CHK, EXEC, RESP.
  - H0: waits for AA.
  - H1: expects BB. Any other byte goes to H1 if it is AA, otherwise to H0.
  - H2: expects CC, with the same fallback rule as H1.
  - DATA: a byte counter counts DATA_BYTES bytes.
  - CHK goes to EXEC.
  - EXEC lasts one cycle and goes to RESP.
  - RESP returns to H0 once the last response byte is accepted.
- Validation in EXEC, in priority order; the first failure sets the status:
  - checksum mismatch -> 0xE1.
  - CMD not in {01,02,03} -> 0xE2.
  - ADDR >= NUM_REGS for write or read -> 0xE3.
- A rejected frame changes no register, increments err_count (saturates at 255) and returns NAK 0x15 followed by the status byte.
- Accepted frames:
  - write returns ACK 0x06 followed by ADDR.
  - read returns 0x06, ADDR, then DATA_BYTES register bytes MSB first.
  - restore returns 0x06 followed by 0xFF.
  - read does not pulse wr_strobe. restore pulses every wr_strobe bit.
- Timeout: a gap counter is cleared on every accepted rx byte and runs in states H1..CHK. When it reaches TIMEOUT_CYC the FSM returns to H0, the partial frame is discarded, err_count increments and no response is sent.
- rx bytes arriving in EXEC or RESP are discarded and not counted; response transmission is never interrupted.
- Reset (reset_n=0):
  - regs_flat = DEFAULTS.
  - wr_strobe = 0, cmd_pulse = 0, tx_valid = 0, tx_data = 0, err_count = 0.
  - FSM in H0, all counters zero.
  - Reset asserted mid-frame or mid-response aborts it immediately; no partial response completes.

## Timing
- Byte acceptance: one byte per rx_valid cycle; back-to-back rx_valid on consecutive cycles must be supported.
- Let cycle N be the cycle CHK is sampled.
  - N+1: EXEC.
  - N+2: register update visible on regs_flat, together with wr_strobe and cmd_pulse.
  - N+2: tx_valid rises with the first response byte.
- Transmit handshake:
  - Each byte transfers on a cycle with tx_valid=1 and tx_ready=1.
  - The next byte is presented on the following cycle.
  - tx_data and tx_valid are stable while tx_ready=0.
  - tx_valid drops the cycle after the last transfer.
- A read returns the register value as of EXEC, so a write earlier in the same cycle is not possible.
- Rejected-frame latency matches accepted frames: NAK is presented at N+2.
- Arithmetic: ADDR is compared as an 8-bit unsigned value against NUM_REGS. err_count holds at 255.

## Test plan
- Reset with DEFAULTS reg1=0x0000_0FA0 -> regs_flat reg1 = 0x00000FA0, tx_valid=0, err_count=0.
- Frame AA BB CC 01 03 12 34 56 78 CHK=0x0A, bytes back-to-back -> reg3=0x12345678 at N+2, wr_strobe[3] pulses once, tx bytes 06 03.
- Read frame 02 03 00 00 00 00 CHK=0x01 with tx_ready toggling 1,0,0,1,... -> bytes 06 03 12 34 56 78 in order, each held stable while tx_ready=0.
- Write frame with a corrupted checksum, then write to addr 0x20 -> NAK 15 E1, then NAK 15 E3; no register changes; err_count=2.
- Bytes AA AA BB CC ... (valid write to reg0) -> resynchronises and executes. A separate partial frame AA BB CC 01 followed by a TIMEOUT_CYC gap -> back to H0, err_count+1, no response.
- Restore after several writes -> all registers equal DEFAULTS, wr_strobe all ones for one cycle, tx bytes 06 FF. Reset asserted mid-response -> tx_valid=0 on the next cycle.
